// File: rtl/ifft_cp_pkg.sv
// ---------------------------------------------------------------------------
// ifft_cp_pkg
//   Shared definitions for the cyclic-prefix insertion stage of the IFFT_CP
//   chain: default symbol geometry, reader state encoding and the address
//   bit-reversal helper used when the IFFT delivers bit-reversed output.
// ---------------------------------------------------------------------------
package ifft_cp_pkg;

  localparam int N_DEFAULT      = 2048;
  localparam int CP_LEN_DEFAULT = 144;
  localparam int ADDR_W         = $clog2(N_DEFAULT);

  // Reader phases: waiting for a full bank, replaying the tail, replaying the
  // whole symbol.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CP   = 2'd1,
    SYM  = 2'd2
  } rd_state_t;

  // Reverse the low 'bits' bits of 'a'; upper bits of the result are zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] a, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) begin
      r[i] = a[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cp_bank_ram.sv
// ---------------------------------------------------------------------------
// cp_bank_ram
//   Simple dual-port synchronous RAM holding both ping-pong banks. The bank
//   select is the MSB of the address ({bank, addr}).
//   Ports:
//     clk           clock
//     we/waddr/wdata  write port (written on rising edge when we)
//     re/raddr      read request
//     rdata         registered read data, valid the cycle after re
// ---------------------------------------------------------------------------
module cp_bank_ram #(
  parameter int DATA_W = 52,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // NOTE: the storage array and its read register carry no reset so the
  // array maps onto block RAM; the reader's valid pipeline masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cp_insert.sv
// ---------------------------------------------------------------------------
// cp_insert
//   Cyclic-prefix insertion. Buffers each N-sample symbol from the IFFT in a
//   ping-pong RAM and replays it as CP_LEN tail samples followed by the whole
//   symbol. Upstream back-pressure via IN_READY; no downstream back-pressure.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     data_in_r/_i, VALID      input sample stream (accepted on VALID && IN_READY)
//     IN_READY                 the current write bank is free
//     data_out_r/_i, OUT_VALID registered output stream
//     SYM_START                pulse with the first CP sample of each symbol
//     OVERFLOW                 sticky: VALID seen while IN_READY low
//   Build option:
//     CP_BITREV_IN_EN          store input at bit-reversed write address so a
//                              bit-reversed input stream lands in natural order
// ---------------------------------------------------------------------------
module cp_insert
  import ifft_cp_pkg::*;
#(
  parameter int WIDTH  = 26,
  parameter int N      = N_DEFAULT,
  parameter int CP_LEN = CP_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in_r,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] data_out_r,
  output logic [WIDTH-1:0] data_out_i,
  output logic             OUT_VALID,
  output logic             SYM_START,
  output logic             OVERFLOW
);

  localparam int              AW       = $clog2(N);
  localparam logic [AW-1:0]   LAST     = AW'(N - 1);
  localparam logic [AW-1:0]   CP_FIRST = AW'(N - CP_LEN);

  // ---------------- writer ----------------
  logic [1:0]    full_q;
  logic          wr_bank_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] wr_row;
  logic          accept;
  logic          wr_last;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  // ---------------- reader ----------------
  rd_state_t     state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_en;
  logic          rd_first;
  logic          rd_done;
  logic          in_sym;
  logic          rd_valid_q;
  logic          rd_first_q;
  logic [2*WIDTH-1:0] rd_data;

  assign IN_READY = !full_q[wr_bank_q];
  assign accept   = VALID && IN_READY;
  assign wr_last  = accept && (wr_addr_q == LAST);

`ifdef CP_BITREV_IN_EN
  assign wr_row = AW'(bit_rev(32'(wr_addr_q), AW));
`else
  assign wr_row = wr_addr_q;
`endif

  // The writer only fills a free bank and the reader only drains a full one,
  // so a same-cycle set and clear always hit different banks.
  assign full_set = {wr_last & wr_bank_q, wr_last & ~wr_bank_q};
  assign full_clr = {rd_done & rd_bank_q, rd_done & ~rd_bank_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      full_q <= (full_q | full_set) & ~full_clr;
      if (accept) begin
        wr_addr_q <= wr_addr_q + 1'b1;  // N is a power of two: wraps at N-1
      end
      if (wr_last) begin
        wr_bank_q <= !wr_bank_q;
      end
      if (VALID && !IN_READY) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  // Reader: rd_addr_q is the address issued in the current cycle. The first
  // CP read is issued straight from IDLE so the first output lands two cycles
  // after the bank is seen full.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_first  = 1'b0;
    rd_done   = 1'b0;
    in_sym    = (state_q == SYM);

    case (state_q)
      IDLE:    rd_en = full_q[rd_bank_q];
      CP, SYM: rd_en = 1'b1;
      default: rd_en = 1'b0;
    endcase

    if (rd_en) begin
      rd_first = !in_sym && (rd_addr_q == CP_FIRST);
      if (rd_addr_q != LAST) begin
        rd_addr_d = rd_addr_q + 1'b1;
        state_d   = in_sym ? SYM : CP;
      end else if (!in_sym) begin
        rd_addr_d = '0;
        state_d   = SYM;
      end else begin
        rd_done   = 1'b1;
        rd_bank_d = !rd_bank_q;
        rd_addr_d = CP_FIRST;
        state_d   = full_q[!rd_bank_q] ? CP : IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= CP_FIRST;
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      OUT_VALID  <= 1'b0;
      SYM_START  <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_en;
      rd_first_q <= rd_first;
      OUT_VALID  <= rd_valid_q;
      SYM_START  <= rd_first_q;
      if (rd_valid_q) begin
        {data_out_r, data_out_i} <= rd_data;
      end else begin
        data_out_r <= '0;
        data_out_i <= '0;
      end
    end
  end

  cp_bank_ram #(
    .DATA_W (2 * WIDTH),
    .AW     (AW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr ({wr_bank_q, wr_row}),
    .wdata ({data_in_r, data_in_i}),
    .re    (rd_en),
    .raddr ({rd_bank_q, rd_addr_q}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_cp_insert.sv
// ---------------------------------------------------------------------------
// tb_cp_insert
//   Self-checking bench for cp_insert at default geometry (N=2048, CP=144).
//   Frame f, input index k carries re = f*N + k, im = -re, so every output
//   sample identifies its frame and position. With CP_BITREV_IN_EN defined the
//   same frames are fed in bit-reversed index order.
// ---------------------------------------------------------------------------
module tb_cp_insert;

  localparam int WIDTH  = 26;
  localparam int N      = 2048;
  localparam int CP_LEN = 144;
  localparam int LOGN   = 11;
  localparam int L      = N + CP_LEN;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [WIDTH-1:0] data_in_r = '0;
  logic signed [WIDTH-1:0] data_in_i = '0;
  logic                    VALID = 1'b0;
  logic                    IN_READY;
  logic signed [WIDTH-1:0] data_out_r;
  logic signed [WIDTH-1:0] data_out_i;
  logic                    OUT_VALID;
  logic                    SYM_START;
  logic                    OVERFLOW;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int last0_cyc = 0;
  int fc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cp_insert #(.WIDTH(WIDTH), .N(N), .CP_LEN(CP_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .VALID      (VALID),
    .IN_READY   (IN_READY),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .OUT_VALID  (OUT_VALID),
    .SYM_START  (SYM_START),
    .OVERFLOW   (OVERFLOW)
  );

  typedef struct {
    int frames;
    int gapped;
    int honour;
    int exp_syms;
    int exp_ovf;
  } scen_t;

  scen_t scen [4];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int in_index(input int k);
    int r;
    r = k;
`ifdef CP_BITREV_IN_EN
    r = 0;
    for (int i = 0; i < LOGN; i++) r[LOGN-1-i] = k[i];
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    VALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_frames(input int nfr, input int base, input int gapped, input int honour);
    int  stall;
    int  v;
    bit  sent;
    stall = 0;
    for (int f = 0; f < nfr; f++) begin
      for (int k = 0; k < N; k++) begin
        v    = (base + f) * N + in_index(k);
        sent = 1'b0;
        while (!sent) begin
          @(negedge clk);
          if (honour == 0 && f == 2 && k == 0) check("ovf_before_reject", OVERFLOW, 0);
          if (honour == 0 && f == 2 && k == 1) check("ovf_rise", OVERFLOW, 1);
          if ((gapped != 0 && $urandom_range(0, 1) == 0) || (honour != 0 && !IN_READY)) begin
            VALID = 1'b0;
            stall++;
            if (stall > 60000) begin
              check("drive_budget", stall, 60000);
              VALID = 1'b0;
              return;
            end
          end else begin
            VALID     = 1'b1;
            data_in_r = WIDTH'(v);
            data_in_i = WIDTH'(-v);
            sent      = 1'b1;
            if (f == 0 && k == N - 1) last0_cyc = cyc;
          end
        end
      end
    end
    @(negedge clk);
    VALID = 1'b0;
  endtask

  task automatic monitor(input int nsym, input int base, output int first_cyc);
    int waited, errs, bad_j, idx, v;
    logic signed [WIDTH-1:0] er, ei, br, bi;
    logic bv, bs;
    first_cyc = -1;
    waited    = 0;
    @(negedge clk);
    while (!OUT_VALID && waited < 30000) begin
      @(negedge clk);
      waited++;
    end
    check("first_out_wait", OUT_VALID, 1);
    if (!OUT_VALID) return;
    first_cyc = cyc;
    for (int s = 0; s < nsym; s++) begin
      errs  = 0;
      bad_j = -1;
      br = '0; bi = '0; bv = 1'b0; bs = 1'b0;
      for (int j = 0; j < L; j++) begin
        if (s != 0 || j != 0) @(negedge clk);
        idx = (j < CP_LEN) ? (N - CP_LEN + j) : (j - CP_LEN);
        v   = (base + s) * N + idx;
        er  = WIDTH'(v);
        ei  = WIDTH'(-v);
        if (OUT_VALID !== 1'b1 || data_out_r !== er || data_out_i !== ei ||
            SYM_START !== (j == 0)) begin
          errs++;
          if (bad_j < 0) begin
            bad_j = j; br = data_out_r; bi = data_out_i; bv = OUT_VALID; bs = SYM_START;
          end
        end
      end
      check($sformatf("sym%0d_bad_samples", s), errs, 0);
      if (errs != 0) begin
        v = (base + s) * N + ((bad_j < CP_LEN) ? (N - CP_LEN + bad_j) : (bad_j - CP_LEN));
        $display("  first bad j=%0d valid=%b start=%b re=%0d im=%0d want re=%0d im=%0d",
                 bad_j, bv, bs, br, bi, v, -v);
      end
    end
    @(negedge clk);
    check("valid_falls_after_last", OUT_VALID, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    // frames, gapped, honour IN_READY, expected symbols out, expected OVERFLOW
    scen[0] = '{1, 0, 1, 1, 0};   // single frame, continuous
    scen[1] = '{1, 1, 1, 1, 0};   // single frame, random gaps
    scen[2] = '{4, 0, 1, 4, 0};   // back-to-back, gapless output
    scen[3] = '{3, 0, 0, 2, 1};   // IN_READY ignored: frame 2 starts rejected

    // Reset state
    do_reset();
    check("rst_in_ready",  IN_READY,   1);
    check("rst_out_valid", OUT_VALID,  0);
    check("rst_sym_start", SYM_START,  0);
    check("rst_overflow",  OVERFLOW,   0);
    check("rst_data_r",    data_out_r, 0);
    check("rst_data_i",    data_out_i, 0);

    for (int i = 0; i < 4; i++) begin
      do_reset();
      fork
        drive_frames(scen[i].frames, 0, scen[i].gapped, scen[i].honour);
        monitor(scen[i].exp_syms, 0, fc);
      join
      check($sformatf("s%0d_latency", i), fc - last0_cyc, 3);
      check($sformatf("s%0d_overflow", i), OVERFLOW, scen[i].exp_ovf);
    end

    // Reset in the middle of symbol 0 readout, then a fresh frame.
    do_reset();
    drive_frames(1, 0, 0, 1);
    highs = 0;
    while (!OUT_VALID && highs < 100) begin
      @(negedge clk);
      highs++;
    end
    repeat (500) @(negedge clk);
    check("mid_valid_before_rst", OUT_VALID, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", OUT_VALID,  0);
    check("mid_rst_data_r",    data_out_r, 0);
    check("mid_rst_data_i",    data_out_i, 0);
    check("mid_rst_sym_start", SYM_START,  0);
    check("mid_rst_in_ready",  IN_READY,   1);
    @(negedge clk);
    rst   = 1'b0;
    highs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (OUT_VALID) highs++;
    end
    check("mid_no_resume", highs, 0);
    fork
      drive_frames(1, 7, 0, 1);
      monitor(1, 7, fc);
    join
    check("mid_fresh_latency", fc - last0_cyc, 3);
    check("mid_fresh_overflow", OVERFLOW, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
